// File: rtl/lockin_array_if.sv
// Stream/bus bundle of the lock-in array: reference-tick samples in, demodulated frames out.
// The slave modport is the demodulator; the master modport is its driver/consumer.
interface lockin_array_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned OUT_W  = 32
);
    logic                     tick_i;
    logic [N_CH*DATA_W-1:0]   data_i;
    logic [DATA_W-1:0]        sin_i;
    logic [DATA_W-1:0]        cos_i;
    logic                     ready_i;
    logic                     clear_i;
    logic [N_CH*OUT_W-1:0]    i_o;
    logic [N_CH*OUT_W-1:0]    q_o;
    logic                     valid_o;
    logic                     busy_o;
    logic [1:0]               overrun_o;
    logic [31:0]              frame_cnt_o;

    modport slave (
        input  tick_i, data_i, sin_i, cos_i, ready_i, clear_i,
        output i_o, q_o, valid_o, busy_o, overrun_o, frame_cnt_o
    );

    modport master (
        output tick_i, data_i, sin_i, cos_i, ready_i, clear_i,
        input  i_o, q_o, valid_o, busy_o, overrun_o, frame_cnt_o
    );
endinterface

// File: rtl/lockin_array.sv
// Multi-channel lock-in demodulator: one shared I/Q multiplier pair walks the channels after
// each reference tick, accumulating DECIM samples per frame before a saturating dump.
module lockin_array #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned ACC_W     = 56,
    parameter int unsigned DECIM     = 64,
    parameter int unsigned OUT_SHIFT = 6,
    parameter int unsigned OUT_W     = 32
) (
    input logic           clk_i,
    input logic           reset_i,
    lockin_array_if.slave bus
);
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StMac, StDump} state_e;

    state_e                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N_CH*DATA_W-1:0]   data_q, data_d;
    logic signed [DATA_W-1:0] sin_q, sin_d, cos_q, cos_d;
    logic signed [ACC_W-1:0]  acc_i_q [N_CH];
    logic signed [ACC_W-1:0]  acc_i_d [N_CH];
    logic signed [ACC_W-1:0]  acc_q_q [N_CH];
    logic signed [ACC_W-1:0]  acc_q_d [N_CH];
    logic [N_CH*OUT_W-1:0]    i_q, i_d, q_q, q_d;
    logic                     valid_q, valid_d, busy_q, busy_d;
    logic [1:0]               ovr_q, ovr_d;
    logic [31:0]              frame_cnt_q, frame_cnt_d;

    logic signed [DATA_W-1:0] sample;
    logic signed [PROD_W-1:0] prod_i, prod_q;

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [PROD_W-1:0] p);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W + 1 - PROD_W){p[PROD_W-1]}}, p};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    // Output fits only if every bit above the OUT_W sign position agrees with it.
    function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        logic [ACC_W-OUT_W:0]    top;
        sh  = a >>> OUT_SHIFT;
        top = sh[ACC_W-1:OUT_W-1];
        if ((&top) || !(|top)) begin
            sat_out = sh[OUT_W-1:0];
        end else if (sh[ACC_W-1]) begin
            sat_out = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    always_comb begin
        sample = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == CH_W'(k)) sample = data_q[k*DATA_W +: DATA_W];
        end
        prod_i = $signed({{DATA_W{sample[DATA_W-1]}}, sample}) *
                 $signed({{DATA_W{sin_q[DATA_W-1]}}, sin_q});
        prod_q = $signed({{DATA_W{sample[DATA_W-1]}}, sample}) *
                 $signed({{DATA_W{cos_q[DATA_W-1]}}, cos_q});
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        i_d         = i_q;
        q_d         = q_q;
        valid_d     = valid_q;
        ovr_d       = bus.clear_i ? 2'b00 : ovr_q;
        frame_cnt_d = frame_cnt_q;

        if (valid_q && bus.ready_i) begin
            valid_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.tick_i) begin
                    data_d  = bus.data_i;
                    sin_d   = bus.sin_i;
                    cos_d   = bus.cos_i;
                    ch_d    = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_q == CH_W'(k)) begin
                        acc_i_d[k] = sat_add(acc_i_q[k], prod_i);
                        acc_q_d[k] = sat_add(acc_q_q[k], prod_q);
                    end
                end
                if (ch_q == CH_W'(N_CH - 1)) begin
                    if (cnt_q == CNT_W'(DECIM - 1)) begin
                        cnt_d   = '0;
                        state_d = StDump;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StDump: begin
                // A pending unconsumed frame has priority; the new one is dropped.
                if (!valid_q || bus.ready_i) begin
                    for (int k = 0; k < N_CH; k++) begin
                        i_d[k*OUT_W +: OUT_W] = sat_out(acc_i_q[k]);
                        q_d[k*OUT_W +: OUT_W] = sat_out(acc_q_q[k]);
                    end
                    valid_d = 1'b1;
                end else begin
                    ovr_d[1] = 1'b1;
                end
                for (int k = 0; k < N_CH; k++) begin
                    acc_i_d[k] = '0;
                    acc_q_d[k] = '0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.tick_i && (state_q != StIdle)) ovr_d[0] = 1'b1;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            for (int k = 0; k < N_CH; k++) begin
                acc_i_q[k] <= '0;
                acc_q_q[k] <= '0;
            end
            i_q         <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 2'b00;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            i_q         <= i_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.i_o         = i_q;
    assign bus.q_o         = q_q;
    assign bus.valid_o     = valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.overrun_o   = ovr_q;
    assign bus.frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_lockin_array.sv
// Bench for lockin_array: a per-sample arithmetic model of the demodulator is compared with
// the DUT every cycle, plus literal frame values for the directed scenarios.
module tb_lockin_array;
    localparam int unsigned N_CH      = 2;
    localparam int unsigned DATA_W    = 24;
    localparam int unsigned ACC_W     = 48;
    localparam int unsigned DECIM     = 4;
    localparam int unsigned OUT_SHIFT = 2;
    localparam int unsigned OUT_W     = 32;
    localparam int unsigned OW        = N_CH * OUT_W;

    localparam logic [OW-1:0] I_A   = {32'hFFFFFC18, 32'h000007D0};  // -1000, 2000
    localparam logic [OW-1:0] Q_A   = {32'h000005DC, 32'hFFFFF448};  // 1500, -3000
    localparam logic [OW-1:0] I_B   = {32'hFFFFFC7C, 32'h000002BC};  // -900, 700
    localparam logic [OW-1:0] I_SAT = {32'h80000000, 32'h7FFFFFFF};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    lockin_array_if #(.N_CH(N_CH), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    lockin_array #(
        .N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .DECIM(DECIM),
        .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    longint acc_i_m [N_CH];
    longint acc_q_m [N_CH];
    longint fr_i_m  [N_CH];
    longint fr_q_m  [N_CH];
    longint out_i_m [N_CH];
    longint out_q_m [N_CH];
    bit       valid_m = 0;
    bit [1:0] ov_m = 0;
    int unsigned fc_m = 0;
    int       samples_m = 0;
    longint   ecnt = 0;
    longint   busy_until_m = 0;
    longint   dump_due_m = -1;
    bit       started = 0;

    function automatic longint clamp(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint chan(input int k);
        logic signed [DATA_W-1:0] v;
        v = bus.data_i[k*DATA_W +: DATA_W];
        return longint'(v);
    endfunction

    task automatic model_step();
        bit hs, was_valid, busy_before, dumping;
        longint s, c;
        ecnt++;
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_i_m[k] = 0; acc_q_m[k] = 0; out_i_m[k] = 0; out_q_m[k] = 0;
            end
            valid_m = 0; ov_m = 0; fc_m = 0; samples_m = 0;
            busy_until_m = ecnt; dump_due_m = -1; started = 1;
            return;
        end
        was_valid   = valid_m;
        hs          = valid_m && bus.ready_i;
        busy_before = (ecnt - 1) < busy_until_m;
        if (hs) begin valid_m = 0; fc_m++; end
        if (bus.clear_i) ov_m = 0;
        if (ecnt == dump_due_m) begin
            if (!was_valid || bus.ready_i) begin
                for (int k = 0; k < N_CH; k++) begin
                    out_i_m[k] = fr_i_m[k]; out_q_m[k] = fr_q_m[k];
                end
                valid_m = 1;
            end else begin
                ov_m[1] = 1;
            end
        end
        if (bus.tick_i) begin
            if (busy_before) begin
                ov_m[0] = 1;
            end else begin
                s = longint'($signed(bus.sin_i));
                c = longint'($signed(bus.cos_i));
                for (int k = 0; k < N_CH; k++) begin
                    acc_i_m[k] = clamp(acc_i_m[k] + chan(k) * s, ACC_W);
                    acc_q_m[k] = clamp(acc_q_m[k] + chan(k) * c, ACC_W);
                end
                samples_m++;
                dumping = (samples_m == DECIM);
                busy_until_m = ecnt + N_CH + (dumping ? 1 : 0);
                if (dumping) begin
                    samples_m = 0;
                    for (int k = 0; k < N_CH; k++) begin
                        fr_i_m[k] = clamp(acc_i_m[k] >>> OUT_SHIFT, OUT_W);
                        fr_q_m[k] = clamp(acc_q_m[k] >>> OUT_SHIFT, OUT_W);
                        acc_i_m[k] = 0; acc_q_m[k] = 0;
                    end
                    dump_due_m = ecnt + N_CH + 1;
                end
            end
        end
    endtask

    task automatic compare();
        logic [OW-1:0] ei, eq;
        longint t;
        for (int k = 0; k < N_CH; k++) begin
            t = out_i_m[k]; ei[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
            t = out_q_m[k]; eq[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
        end
        check("i_o", 128'(bus.i_o), 128'(ei));
        check("q_o", 128'(bus.q_o), 128'(eq));
        check("valid_o", 128'(bus.valid_o), 128'(valid_m));
        check("busy_o", 128'(bus.busy_o), 128'(ecnt < busy_until_m));
        check("overrun_o", 128'(bus.overrun_o), 128'(ov_m));
        check("frame_cnt_o", 128'(bus.frame_cnt_o), 128'(fc_m));
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (started) compare();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input int c0, input int c1, input int s, input int c);
        logic [DATA_W-1:0] a, b;
        a = DATA_W'(c0);
        b = DATA_W'(c1);
        bus.data_i = {b, a};
        bus.sin_i  = DATA_W'(s);
        bus.cos_i  = DATA_W'(c);
    endtask

    // Called at a negedge; returns at the next negedge with tick released.
    task automatic send_tick(input int c0, input int c1, input int s, input int c);
        set_in(c0, c1, s, c);
        bus.tick_i = 1'b1;
        @(negedge clk);
        bus.tick_i = 1'b0;
    endtask

    task automatic ticks(input int n, input int c0, input int c1, input int s, input int c);
        for (int i = 0; i < n; i++) begin
            send_tick(c0, c1, s, c);
            if (i < n - 1) cyc(N_CH + 1);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL valid_timeout: valid_o never rose within 20 cycles");
        end
    endtask

    task automatic clear_pulse();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    initial begin : stim
        int lat;
        bus.tick_i = 0; bus.ready_i = 0; bus.clear_i = 0;
        set_in(0, 0, 0, 0);
        cyc(2);
        reset = 1'b0;
        check("rst_i_o", 128'(bus.i_o), 128'(0));
        check("rst_valid", 128'(bus.valid_o), 128'(0));
        check("rst_busy", 128'(bus.busy_o), 128'(0));
        check("rst_fc", 128'(bus.frame_cnt_o), 128'(0));
        bus.ready_i = 1'b1;
        cyc(1);

        // Basic frame and latency
        ticks(4, 1000, -500, 2, -3);
        wait_valid(lat);
        check("valid_latency", 128'(lat + 1), 128'(N_CH + 2));
        check("t1_i", 128'(bus.i_o), 128'(I_A));
        check("t1_q", 128'(bus.q_o), 128'(Q_A));
        check("t1_fc_pre", 128'(bus.frame_cnt_o), 128'(0));
        cyc(1);
        check("t1_fc", 128'(bus.frame_cnt_o), 128'(1));
        check("t1_valid_drop", 128'(bus.valid_o), 128'(0));
        cyc(2);

        // Accumulator and output saturation
        ticks(4, -8388608, 8388607, -8388608, 5);
        wait_valid(lat);
        check("t2_sat_i", 128'(bus.i_o), 128'(I_SAT));
        cyc(3);

        // Tick during busy is dropped and flagged
        set_in(1000, -500, 2, -3);
        bus.tick_i = 1'b1;
        @(negedge clk);
        set_in(9999, 9999, 9999, 9999);
        @(negedge clk);
        bus.tick_i = 1'b0;
        check("t3_ovr", 128'(bus.overrun_o), 128'(2'b01));
        cyc(N_CH);
        ticks(3, 1000, -500, 2, -3);
        wait_valid(lat);
        check("t3_i", 128'(bus.i_o), 128'(I_A));
        check("t3_q", 128'(bus.q_o), 128'(Q_A));
        cyc(2);
        clear_pulse();
        check("t3_clear", 128'(bus.overrun_o), 128'(2'b00));

        // Clear coinciding with a new dropped tick: event wins
        set_in(1000, -500, 2, -3);
        bus.tick_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.tick_i = 1'b0;
        bus.clear_i = 1'b0;
        check("t3b_ovr_wins", 128'(bus.overrun_o), 128'(2'b01));
        cyc(N_CH);
        ticks(3, 1000, -500, 2, -3);
        wait_valid(lat);
        cyc(2);
        clear_pulse();

        // Back-pressure across two frames
        bus.ready_i = 1'b0;
        ticks(4, 1000, -500, 2, -3);
        wait_valid(lat);
        cyc(2);
        ticks(4, 7, -9, 100, 50);
        cyc(N_CH + 3);
        check("t4_keep_i", 128'(bus.i_o), 128'(I_A));
        check("t4_keep_q", 128'(bus.q_o), 128'(Q_A));
        check("t4_ovr", 128'(bus.overrun_o), 128'(2'b10));
        check("t4_fc_hold", 128'(bus.frame_cnt_o), 128'(4));
        bus.ready_i = 1'b1;
        cyc(1);
        check("t4_fc", 128'(bus.frame_cnt_o), 128'(5));
        cyc(1);
        clear_pulse();

        // Dump coinciding with handshake replaces the frame without overrun
        bus.ready_i = 1'b0;
        ticks(4, 1000, -500, 2, -3);
        wait_valid(lat);
        cyc(2);
        ticks(4, 7, -9, 100, 50);
        cyc(N_CH);
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        check("t5_valid", 128'(bus.valid_o), 128'(1));
        check("t5_new_i", 128'(bus.i_o), 128'(I_B));
        check("t5_ovr", 128'(bus.overrun_o), 128'(2'b00));
        check("t5_fc", 128'(bus.frame_cnt_o), 128'(6));
        bus.ready_i = 1'b1;
        cyc(1);
        check("t5_fc_next", 128'(bus.frame_cnt_o), 128'(7));
        cyc(2);

        // Reset in the middle of the third sample's MAC
        ticks(2, 1000, -500, 2, -3);
        cyc(N_CH + 1);
        send_tick(1000, -500, 2, -3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_i", 128'(bus.i_o), 128'(0));
        check("t6_rst_fc", 128'(bus.frame_cnt_o), 128'(0));
        check("t6_rst_busy", 128'(bus.busy_o), 128'(0));
        cyc(1);
        ticks(4, 1000, -500, 2, -3);
        wait_valid(lat);
        check("t6_i", 128'(bus.i_o), 128'(I_A));
        check("t6_q", 128'(bus.q_o), 128'(Q_A));
        cyc(1);
        check("t6_fc", 128'(bus.frame_cnt_o), 128'(1));
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
